sat_chan_ctrl: RTL and testbench

SAT_CHAN_CTRL -- requirements
Module: sat_chan_ctrl

---
 rtl/sat_chan_ctrl_if.sv | 13 +
 rtl/sat_chan_ctrl.sv | 138 +++++++++++++
 tb/tb_sat_chan_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_chan_ctrl_if.sv
// rtl/sat_chan_ctrl_if.sv - host configuration write bus for sat_chan_ctrl.
interface sat_chan_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_chan;
  logic [2:0]  cfg_field;
  logic [31:0] cfg_data;

  modport master (output cfg_valid, output cfg_chan, output cfg_field, output cfg_data,
                  input cfg_ready);
  modport slave  (input cfg_valid, input cfg_chan, input cfg_field, input cfg_data,
                  output cfg_ready);
endinterface

// File: rtl/sat_chan_ctrl.sv
// rtl/sat_chan_ctrl.sv - epoch-aligned shadow/active channel parameter controller.
// Optional SAT_CHAN_CTRL_EPOCH_CNT_EN builds the applied-commit counter on epoch_count.
module sat_chan_ctrl #(
  parameter int NUM_CHAN  = 8,
  parameter int EPOCH_LEN = 16368
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dv_in,
  sat_chan_ctrl_if.slave            cfg,
  output logic [NUM_CHAN-1:0][31:0] dop_freq,
  output logic [NUM_CHAN-1:0][31:0] code_freq,
  output logic [NUM_CHAN-1:0][15:0] gain,
  output logic [NUM_CHAN-1:0][5:0]  ca_sel,
  output logic                      epoch_tick,
  output logic                      apply_pulse,
  output logic [31:0]               epoch_count
);

  localparam int CW = $clog2(EPOCH_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(EPOCH_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] sample_cnt;
  logic          cfg_fire;

  logic [NUM_CHAN-1:0][31:0] sh_dop, sh_code, act_dop, act_code;
  logic [NUM_CHAN-1:0][15:0] sh_gain, act_gain;
  logic [NUM_CHAN-1:0][5:0]  sh_ca, act_ca;
  logic [NUM_CHAN-1:0]       sh_en, act_en, pending;

  assign epoch_tick = !reset && dv_in && (sample_cnt == CNT_LAST);
  assign cfg_fire   = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    state_nxt     = state;
    cfg.cfg_ready = 1'b0;
    apply_pulse   = 1'b0;
    case (state)
      IDLE: begin
        cfg.cfg_ready = !reset;
        if (cfg.cfg_valid && cfg.cfg_field == 3'd5)
          state_nxt = ARMED;
      end
      // A tick arriving with the commit itself is seen while still IDLE, so it is not used.
      ARMED: begin
        if (epoch_tick)
          state_nxt = APPLY;
      end
      APPLY: begin
        apply_pulse = !reset;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      sample_cnt <= '0;
    else if (dv_in)
      sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_dop   <= '0;
      sh_code  <= '0;
      sh_gain  <= '0;
      sh_ca    <= '0;
      sh_en    <= '0;
      act_dop  <= '0;
      act_code <= '0;
      act_gain <= '0;
      act_ca   <= '0;
      act_en   <= '0;
      pending  <= '0;
    end else begin
      if (state == APPLY) begin
        for (int i = 0; i < NUM_CHAN; i++) begin
          if (pending[i]) begin
            act_dop[i]  <= sh_dop[i];
            act_code[i] <= sh_code[i];
            act_gain[i] <= sh_gain[i];
            act_ca[i]   <= sh_ca[i];
            act_en[i]   <= sh_en[i];
          end
        end
        pending <= '0;
      end
      // Out-of-range channels simply match no loop index and are dropped.
      if (cfg_fire) begin
        for (int i = 0; i < NUM_CHAN; i++) begin
          if (cfg.cfg_chan == 4'(i)) begin
            case (cfg.cfg_field)
              3'd0: begin sh_dop[i]  <= cfg.cfg_data;       pending[i] <= 1'b1; end
              3'd1: begin sh_code[i] <= cfg.cfg_data;       pending[i] <= 1'b1; end
              3'd2: begin sh_gain[i] <= cfg.cfg_data[15:0]; pending[i] <= 1'b1; end
              3'd3: begin sh_ca[i]   <= cfg.cfg_data[5:0];  pending[i] <= 1'b1; end
              3'd4: begin sh_en[i]   <= cfg.cfg_data[0];    pending[i] <= 1'b1; end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    dop_freq  = act_dop;
    code_freq = act_code;
    ca_sel    = act_ca;
    gain      = '0;
    for (int i = 0; i < NUM_CHAN; i++)
      gain[i] = act_en[i] ? act_gain[i] : 16'h0000;
  end

`ifdef SAT_CHAN_CTRL_EPOCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      epoch_count <= '0;
    else if (state == APPLY)
      epoch_count <= epoch_count + 32'd1;
  end
`else
  assign epoch_count = 32'd0;
`endif

endmodule

// File: tb/tb_sat_chan_ctrl.sv
// tb/tb_sat_chan_ctrl.sv - self-checking bench for sat_chan_ctrl with reference model.
module tb_sat_chan_ctrl;
  localparam int NC = 4;
  localparam int EL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, dv_in;
  logic [NC-1:0][31:0] dop_freq, code_freq;
  logic [NC-1:0][15:0] gain;
  logic [NC-1:0][5:0]  ca_sel;
  logic epoch_tick, apply_pulse;
  logic [31:0] epoch_count;

  sat_chan_ctrl_if cfg_bus();

  sat_chan_ctrl #(.NUM_CHAN(NC), .EPOCH_LEN(EL)) dut (
    .clk(clk), .reset(reset), .dv_in(dv_in), .cfg(cfg_bus),
    .dop_freq(dop_freq), .code_freq(code_freq), .gain(gain), .ca_sel(ca_sel),
    .epoch_tick(epoch_tick), .apply_pulse(apply_pulse), .epoch_count(epoch_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: sample position, outstanding commit, apply due this cycle.
  int m_cnt;
  bit m_busy, m_apply;
  int unsigned m_ecnt;
  logic [31:0] s_dop[NC], s_code[NC], a_dop[NC], a_code[NC];
  logic [15:0] s_gain[NC], a_gain[NC];
  logic [5:0]  s_ca[NC], a_ca[NC];
  bit s_en[NC], a_en[NC], m_pend[NC];
  bit seen_apply;

  typedef struct {
    logic [3:0]  chan;
    logic [2:0]  field;
    logic [31:0] data;
    int          chk_ch;
    logic [31:0] e_dop;
    logic [31:0] e_code;
    logic [15:0] e_gain;
    logic [5:0]  e_ca;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_busy = 0; m_apply = 0; m_ecnt = 0;
    for (int i = 0; i < NC; i++) begin
      s_dop[i] = 0; s_code[i] = 0; s_gain[i] = 0; s_ca[i] = 0; s_en[i] = 0;
      a_dop[i] = 0; a_code[i] = 0; a_gain[i] = 0; a_ca[i] = 0; a_en[i] = 0;
      m_pend[i] = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit d, input bit v, input logic [3:0] c,
                     input logic [2:0] f, input logic [31:0] x);
    bit e_ready, e_tick, e_apl;
    logic [31:0] e_ec;
    reset = r; dv_in = d;
    cfg_bus.cfg_valid = v; cfg_bus.cfg_chan = c; cfg_bus.cfg_field = f; cfg_bus.cfg_data = x;
    #3;
    e_ready = !r && !m_busy && !m_apply;
    e_tick  = !r && d && (m_cnt == EL - 1);
    e_apl   = !r && m_apply;
    chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(e_ready));
    chk("epoch_tick", 32'(epoch_tick), 32'(e_tick));
    chk("apply_pulse", 32'(apply_pulse), 32'(e_apl));
    seen_apply = apply_pulse;
    if (r) model_reset();
    else begin
      if (m_apply) begin
        for (int i = 0; i < NC; i++) begin
          if (m_pend[i]) begin
            a_dop[i] = s_dop[i]; a_code[i] = s_code[i]; a_gain[i] = s_gain[i];
            a_ca[i] = s_ca[i]; a_en[i] = s_en[i];
          end
          m_pend[i] = 0;
        end
        m_ecnt++;
        m_apply = 0;
      end else if (m_busy && e_tick) begin
        m_busy = 0;
        m_apply = 1;
      end
      if (v && e_ready) begin
        if (f == 3'd5) m_busy = 1;
        else if (int'(c) < NC && f < 3'd5) begin
          case (f)
            3'd0: s_dop[c]  = x;
            3'd1: s_code[c] = x;
            3'd2: s_gain[c] = x[15:0];
            3'd3: s_ca[c]   = x[5:0];
            default: s_en[c] = x[0];
          endcase
          m_pend[c] = 1;
        end
      end
      if (d) m_cnt = (m_cnt + 1) % EL;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("dop_freq[%0d]", i), dop_freq[i], a_dop[i]);
      chk($sformatf("code_freq[%0d]", i), code_freq[i], a_code[i]);
      chk($sformatf("gain[%0d]", i), 32'(gain[i]), a_en[i] ? 32'(a_gain[i]) : 32'd0);
      chk($sformatf("ca_sel[%0d]", i), 32'(ca_sel[i]), 32'(a_ca[i]));
    end
`ifdef SAT_CHAN_CTRL_EPOCH_CNT_EN
    e_ec = m_ecnt;
`else
    e_ec = 32'd0;
`endif
    chk("epoch_count", epoch_count, e_ec);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 4'd0, 3'd0, 32'd0);
  endtask

  task automatic wait_apply(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      idle();
      if (seen_apply) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("apply_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cnt(input int target);
    for (int k = 0; k < 40; k++) begin
      if (m_cnt == target) break;
      idle();
    end
  endtask

  initial begin
    int n;
    int any_apply;
    logic [31:0] e_ec3;
    tbl[0] = '{4'd0, 3'd0, 32'h01000000, 0, 32'h01000000, 32'h0, 16'h0000, 6'h00};
    tbl[1] = '{4'd0, 3'd2, 32'h00004000, 0, 32'h01000000, 32'h0, 16'h0000, 6'h00};
    tbl[2] = '{4'd0, 3'd4, 32'h00000001, 0, 32'h01000000, 32'h0, 16'h4000, 6'h00};
    tbl[3] = '{4'd0, 3'd3, 32'hFFFFFFE5, 0, 32'h01000000, 32'h0, 16'h4000, 6'h25};
    tbl[4] = '{4'd2, 3'd2, 32'h12347FFF, 2, 32'h0, 32'h0, 16'h0000, 6'h00};
    tbl[5] = '{4'd2, 3'd4, 32'hFFFFFFFF, 2, 32'h0, 32'h0, 16'h7FFF, 6'h00};
    tbl[6] = '{4'd5, 3'd0, 32'h0000DEAD, 0, 32'h01000000, 32'h0, 16'h4000, 6'h25};
    tbl[7] = '{4'd1, 3'd6, 32'h00000055, 1, 32'h0, 32'h0, 16'h0000, 6'h00};
    tbl[8] = '{4'd1, 3'd1, 32'h00400000, 1, 32'h0, 32'h00400000, 16'h0000, 6'h00};
    tbl[9] = '{4'd2, 3'd4, 32'h00000000, 2, 32'h0, 32'h0, 16'h0000, 6'h00};

    reset = 1; dv_in = 0;
    cfg_bus.cfg_valid = 0; cfg_bus.cfg_chan = 0; cfg_bus.cfg_field = 0; cfg_bus.cfg_data = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset held with a write offered: nothing accepted, strobes low.
    cyc(1, 1, 1, 4'd0, 3'd0, 32'h1);

    // Commit at counter 3, apply after the counter-15 tick.
    cyc(0, 1, 1, 4'd0, 3'd0, 32'h01000000);
    cyc(0, 1, 1, 4'd0, 3'd2, 32'h00004000);
    cyc(0, 1, 1, 4'd0, 3'd4, 32'h00000001);
    wait_cnt(3);
    cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
    wait_apply(n);
    chk("latency_cnt3", n, 13);
    chk("dop0_applied", dop_freq[0], 32'h01000000);
    chk("gain0_applied", 32'(gain[0]), 32'h4000);
    idle();
    chk("apply_one_cycle", 32'(seen_apply), 32'd0);

    // Commit coinciding with the tick waits a full epoch.
    wait_cnt(15);
    cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
    wait_apply(n);
    chk("latency_on_tick", n, 17);

    // Write held during ARMED is refused, then accepted back in IDLE.
    cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
    repeat (5) cyc(0, 1, 1, 4'd3, 3'd0, 32'h0000AAAA);
    wait_apply(n);
    chk("armed_write_blocked", dop_freq[3], 32'h0);
    cyc(0, 1, 1, 4'd3, 3'd0, 32'h0000AAAA);
    cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
    wait_apply(n);
    chk("idle_write_applied", dop_freq[3], 32'h0000AAAA);

    // Table of single writes, each committed and checked against constants.
    cyc(1, 1, 0, 4'd0, 3'd0, 32'd0);
    for (int t = 0; t < 10; t++) begin
      cyc(0, 1, 1, tbl[t].chan, tbl[t].field, tbl[t].data);
      cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
      wait_apply(n);
      chk($sformatf("tbl%0d_dop", t), dop_freq[tbl[t].chk_ch], tbl[t].e_dop);
      chk($sformatf("tbl%0d_code", t), code_freq[tbl[t].chk_ch], tbl[t].e_code);
      chk($sformatf("tbl%0d_gain", t), 32'(gain[tbl[t].chk_ch]), 32'(tbl[t].e_gain));
      chk($sformatf("tbl%0d_ca", t), 32'(ca_sel[tbl[t].chk_ch]), 32'(tbl[t].e_ca));
    end

    // Reset while ARMED abandons the commit.
    cyc(1, 1, 0, 4'd0, 3'd0, 32'd0);
    cyc(0, 1, 1, 4'd1, 3'd1, 32'h00400000);
    cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
    idle();
    idle();
    cyc(1, 1, 0, 4'd0, 3'd0, 32'd0);
    any_apply = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (seen_apply) any_apply++;
    end
    chk("reset_armed_no_apply", any_apply, 0);
    chk("reset_armed_code1", code_freq[1], 32'h0);

    // Three commits from reset.
    cyc(1, 1, 0, 4'd0, 3'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 4'd0, 3'd5, 32'd0);
      wait_apply(n);
    end
`ifdef SAT_CHAN_CTRL_EPOCH_CNT_EN
    e_ec3 = 32'd3;
`else
    e_ec3 = 32'd0;
`endif
    chk("epoch_count_three", epoch_count, e_ec3);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 5)),
          3'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
